pong_ball_engine: RTL and testbench
===================================

Name: pong_ball_engine

Overview:
- Ball physics and scoring stage for the pong design; directly upstream of the computer-player block, which consumes BALL_H/BALL_V and returns its paddle position.
- Moves the ball once per video frame, bounces it off the top/bottom walls and both paddles, detects misses, and keeps score.
- Feeds BALL_H/BALL_V to the AI and renderer. Drives one-cycle HIT/MISS pulses for sound.

Parameters:
- H_MAX, 640, visible width in px
- V_MAX, 480, visible height in px
- BALL_SIZE, 8, ball edge length in px
- SPEED, 4, px moved per axis per frame
- PADDLE_LEN, 80, paddle height in px
- PADDLE_W, 8, paddle width in px
- PADDLE_L_X, 16, left paddle left edge x
- PADDLE_R_X, 616, right paddle left edge x
- WIN_SCORE, 9, score that ends the game
- SCORE_HOLD, 60, frames the ball is hidden after a point

Ports:
- CLOCK  in  1  system clock
- RESET_N  in  1  asynchronous reset, active-low
- FRAME_TICK  in  1  one-cycle pulse per frame (start of vblank)
- SERVE  in  1  one-cycle pulse: start play / restart after game over
- PADDLE_L  in  8  left paddle top, 2px units (top = PADDLE_L*2)
- PADDLE_R  in  8  right (AI) paddle top, 2px units
- BALL_H  out  11  ball left edge x
- BALL_V  out  11  ball top edge y
- BALL_ACTIVE  out  1  ball visible
- SCORE_L  out  4  left score
- SCORE_R  out  4  right score
- HIT  out  1  one-cycle pulse on paddle bounce
- MISS  out  1  one-cycle pulse on point scored
- GAME_OVER  out  1  high in OVER state

Behaviour:
- Reset (RESET_N low, async):
  - BALL_H=316, BALL_V=236 (centre).
  - dir_h=right, dir_v=down.
  - Scores 0, BALL_ACTIVE=0, HIT=MISS=0, GAME_OVER=0.
  - State IDLE.
- Paddle tops: PADDLE_*×2, clamped to 400 (V_MAX-PADDLE_LEN) if larger.
- All updates are registered: outputs change the cycle after FRAME_TICK/SERVE. No other cycles change ball state.
- States:
  - IDLE: ball centred, BALL_ACTIVE=0. SERVE -> PLAY with BALL_ACTIVE=1. No movement in the SERVE cycle, even if FRAME_TICK coincides.
  - PLAY: on FRAME_TICK compute next_h = H±SPEED, next_v = V±SPEED, then apply the rules below. Wall and paddle rules both apply in the same tick (corner case).
  - SCORED: BALL_ACTIVE=0. Count SCORE_HOLD FRAME_TICKs, then centre the ball and go to PLAY. Serve goes toward the player who conceded; dir_v is kept.
  - OVER: GAME_OVER=1, BALL_ACTIVE=0. SERVE clears scores, centres the ball, sets dir_h=right, and goes to PLAY.
- Vertical walls:
  - Moving down and next_v >= V_MAX-BALL_SIZE: V = 472, dir_v = up.
  - Moving up and V < SPEED: V = 0, dir_v = down.
- Right paddle:
  - Hit condition: dir_h=right, H+BALL_SIZE <= PADDLE_R_X, next_h+BALL_SIZE >= PADDLE_R_X, and vertical overlap (V+BALL_SIZE > top and V < top+PADDLE_LEN).
  - On hit: H = PADDLE_R_X-BALL_SIZE, dir_h = left, HIT pulse.
- Left paddle: mirrored about the face PADDLE_L_X+PADDLE_W (=24). Bounce sets H=24.
- Miss:
  - No hit and next_h >= H_MAX-BALL_SIZE: SCORE_L++.
  - No hit and H < SPEED moving left: SCORE_R++.
  - Either way: MISS pulse, then -> SCORED, or -> OVER if the new score equals WIN_SCORE.
- HIT and MISS never pulse in the same cycle. Scores never exceed WIN_SCORE.
- Arithmetic is 11-bit unsigned. Underflow is prevented by the H<SPEED / V<SPEED checks, which are evaluated before subtracting.
- RESET_N asserted mid-frame or mid-hold returns to the reset state immediately; the hold counter is cleared.

Decomposition:
- Package pong_pkg: screen constants (H_MAX, V_MAX, BALL_SIZE, PADDLE_LEN), state enum (IDLE, PLAY, SCORED, OVER), position width (11).
- One sub-module, pong_hit_detect: combinational plane-crossing plus vertical-overlap check, instantiated once per paddle.

Test Plan:
- Reset: assert RESET_N=0 mid-PLAY -> BALL_H=316, BALL_V=236, scores 0, BALL_ACTIVE=0 immediately, state IDLE.
- Wall bounce: PLAY, V=470, dir down, FRAME_TICK -> V=472, dir_v up; next tick V=468.
- Right paddle hit: H=604, V=200, dir right, PADDLE_R=90 (top 180), FRAME_TICK -> H=608, dir_h left, HIT high exactly one cycle.
- Miss: PADDLE_R=0, V=200, ball moving right -> when next_h >= 632, MISS pulse, SCORE_L 0->1, BALL_ACTIVE=0. After 60 ticks the ball is centred moving right.
- Game over: SCORE_R=8, left miss -> SCORE_R=9, GAME_OVER=1. SERVE -> scores 0, GAME_OVER=0, PLAY.
- SERVE and FRAME_TICK in the same cycle in IDLE -> PLAY, ball stays at 316/236 until the following FRAME_TICK.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared screen geometry, game constants and state encoding for the pong ball engine.
package pong_pkg;

    localparam int POS_W = 11;

    localparam logic [POS_W-1:0] H_MAX      = 11'd640;
    localparam logic [POS_W-1:0] V_MAX      = 11'd480;
    localparam logic [POS_W-1:0] BALL_SIZE  = 11'd8;
    localparam logic [POS_W-1:0] SPEED      = 11'd4;
    localparam logic [POS_W-1:0] PADDLE_LEN = 11'd80;
    localparam logic [POS_W-1:0] PADDLE_W   = 11'd8;
    localparam logic [POS_W-1:0] PADDLE_L_X = 11'd16;
    localparam logic [POS_W-1:0] PADDLE_R_X = 11'd616;

    localparam logic [POS_W-1:0] H_CENTRE   = 11'd316;
    localparam logic [POS_W-1:0] V_CENTRE   = 11'd236;
    localparam logic [POS_W-1:0] PADDLE_MAX = V_MAX - PADDLE_LEN;

    localparam logic [3:0] WIN_SCORE  = 4'd9;
    localparam logic [5:0] SCORE_HOLD = 6'd60;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_SCORED,
        ST_OVER
    } state_t;

    // Paddle inputs are in 2px units; keep the whole paddle on screen.
    function automatic logic [POS_W-1:0] paddle_top(input logic [7:0] p);
        logic [POS_W-1:0] t;
        t = {2'b00, p, 1'b0};
        return (t > PADDLE_MAX) ? PADDLE_MAX : t;
    endfunction

endpackage

// File: rtl/pong_hit_detect.sv
// Paddle contact test: ball crosses the paddle face this frame while overlapping it vertically.
module pong_hit_detect
    import pong_pkg::*;
#(
    parameter bit               RIGHT_SIDE = 1'b1,
    parameter logic [POS_W-1:0] FACE       = PADDLE_R_X
) (
    input  logic             i_toward,
    input  logic [POS_W-1:0] i_h,
    input  logic [POS_W-1:0] i_next_h,
    input  logic [POS_W-1:0] i_v,
    input  logic [POS_W-1:0] i_paddle_top,
    output logic             o_hit
);

    logic w_cross;
    logic w_overlap;

    generate
        if (RIGHT_SIDE) begin : g_right
            assign w_cross = (i_h + BALL_SIZE <= FACE) && (i_next_h + BALL_SIZE >= FACE);
        end else begin : g_left
            assign w_cross = (i_h >= FACE) && (i_next_h <= FACE);
        end
    endgenerate

    assign w_overlap = (i_v + BALL_SIZE > i_paddle_top) && (i_v < i_paddle_top + PADDLE_LEN);
    assign o_hit     = i_toward && w_cross && w_overlap;

endmodule

// File: rtl/pong_ball_engine.sv
// Per-frame ball motion, wall/paddle bounces, miss detection and scoring for pong.
module pong_ball_engine
    import pong_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_frame_tick,
    input  logic             i_serve,
    input  logic [7:0]       i_paddle_l,
    input  logic [7:0]       i_paddle_r,
    output logic [POS_W-1:0] o_ball_h,
    output logic [POS_W-1:0] o_ball_v,
    output logic             o_ball_active,
    output logic [3:0]       o_score_l,
    output logic [3:0]       o_score_r,
    output logic             o_hit,
    output logic             o_miss,
    output logic             o_game_over
);

    state_t           r_state;
    logic [POS_W-1:0] r_h;
    logic [POS_W-1:0] r_v;
    logic             r_dir_r;
    logic             r_dir_d;
    logic [3:0]       r_score_l;
    logic [3:0]       r_score_r;
    logic             r_active;
    logic             r_hit;
    logic             r_miss;
    logic             r_over;
    logic [5:0]       r_hold;

    logic [POS_W-1:0] w_top_l;
    logic [POS_W-1:0] w_top_r;
    logic [POS_W-1:0] w_next_h;
    logic [POS_W-1:0] w_next_v;
    logic             w_hit_l;
    logic             w_hit_r;
    logic             w_miss_r;
    logic             w_miss_l;
    logic             w_wall_bot;
    logic             w_wall_top;
    logic [3:0]       w_score_l_inc;
    logic [3:0]       w_score_r_inc;

    assign w_top_l = paddle_top(i_paddle_l);
    assign w_top_r = paddle_top(i_paddle_r);

    // Guard the subtraction so an edge-adjacent ball never wraps around.
    assign w_next_h = r_dir_r ? (r_h + SPEED) : ((r_h < SPEED) ? '0 : (r_h - SPEED));
    assign w_next_v = r_dir_d ? (r_v + SPEED) : ((r_v < SPEED) ? '0 : (r_v - SPEED));

    pong_hit_detect #(.RIGHT_SIDE(1'b1), .FACE(PADDLE_R_X)) u_hit_r (
        .i_toward     (r_dir_r),
        .i_h          (r_h),
        .i_next_h     (w_next_h),
        .i_v          (r_v),
        .i_paddle_top (w_top_r),
        .o_hit        (w_hit_r)
    );

    pong_hit_detect #(.RIGHT_SIDE(1'b0), .FACE(PADDLE_L_X + PADDLE_W)) u_hit_l (
        .i_toward     (~r_dir_r),
        .i_h          (r_h),
        .i_next_h     (w_next_h),
        .i_v          (r_v),
        .i_paddle_top (w_top_l),
        .o_hit        (w_hit_l)
    );

    assign w_miss_r      = r_dir_r && !w_hit_r && (w_next_h >= H_MAX - BALL_SIZE);
    assign w_miss_l      = !r_dir_r && !w_hit_l && (r_h < SPEED);
    assign w_wall_bot    = r_dir_d && (w_next_v >= V_MAX - BALL_SIZE);
    assign w_wall_top    = !r_dir_d && (r_v < SPEED);
    assign w_score_l_inc = r_score_l + 4'd1;
    assign w_score_r_inc = r_score_r + 4'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_h       <= H_CENTRE;
            r_v       <= V_CENTRE;
            r_dir_r   <= 1'b1;
            r_dir_d   <= 1'b1;
            r_score_l <= '0;
            r_score_r <= '0;
            r_active  <= 1'b0;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
            r_over    <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_serve) begin
                        r_state  <= ST_PLAY;
                        r_active <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (i_frame_tick) begin
                        if (w_miss_r || w_miss_l) begin
                            // Ball stays where it was; it is hidden until the next serve.
                            r_miss   <= 1'b1;
                            r_active <= 1'b0;
                            r_hold   <= '0;
                            if (w_miss_r) begin
                                r_score_l <= w_score_l_inc;
                                r_dir_r   <= 1'b1;
                                r_state   <= (w_score_l_inc == WIN_SCORE) ? ST_OVER : ST_SCORED;
                                r_over    <= (w_score_l_inc == WIN_SCORE);
                            end else begin
                                r_score_r <= w_score_r_inc;
                                r_dir_r   <= 1'b0;
                                r_state   <= (w_score_r_inc == WIN_SCORE) ? ST_OVER : ST_SCORED;
                                r_over    <= (w_score_r_inc == WIN_SCORE);
                            end
                        end else begin
                            if (w_wall_bot) begin
                                r_v     <= V_MAX - BALL_SIZE;
                                r_dir_d <= 1'b0;
                            end else if (w_wall_top) begin
                                r_v     <= '0;
                                r_dir_d <= 1'b1;
                            end else begin
                                r_v <= w_next_v;
                            end
                            if (w_hit_r) begin
                                r_h     <= PADDLE_R_X - BALL_SIZE;
                                r_dir_r <= 1'b0;
                                r_hit   <= 1'b1;
                            end else if (w_hit_l) begin
                                r_h     <= PADDLE_L_X + PADDLE_W;
                                r_dir_r <= 1'b1;
                                r_hit   <= 1'b1;
                            end else begin
                                r_h <= w_next_h;
                            end
                        end
                    end
                end
                ST_SCORED: begin
                    if (i_frame_tick) begin
                        if (r_hold == SCORE_HOLD - 6'd1) begin
                            r_hold   <= '0;
                            r_h      <= H_CENTRE;
                            r_v      <= V_CENTRE;
                            r_active <= 1'b1;
                            r_state  <= ST_PLAY;
                        end else begin
                            r_hold <= r_hold + 6'd1;
                        end
                    end
                end
                ST_OVER: begin
                    if (i_serve) begin
                        r_score_l <= '0;
                        r_score_r <= '0;
                        r_h       <= H_CENTRE;
                        r_v       <= V_CENTRE;
                        r_dir_r   <= 1'b1;
                        r_active  <= 1'b1;
                        r_over    <= 1'b0;
                        r_state   <= ST_PLAY;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ball_h      = r_h;
    assign o_ball_v      = r_v;
    assign o_ball_active = r_active;
    assign o_score_l     = r_score_l;
    assign o_score_r     = r_score_r;
    assign o_hit         = r_hit;
    assign o_miss        = r_miss;
    assign o_game_over   = r_over;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Randomized game play against a frame-level reference model, checked through a scoreboard queue.
module tb_pong_ball_engine;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        serve;
    logic [7:0]  pl;
    logic [7:0]  pr;
    logic [10:0] ball_h;
    logic [10:0] ball_v;
    logic        ball_active;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
    logic        hit;
    logic        miss;
    logic        game_over;

    pong_ball_engine dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_tick  (tick),
        .i_serve       (serve),
        .i_paddle_l    (pl),
        .i_paddle_r    (pr),
        .o_ball_h      (ball_h),
        .o_ball_v      (ball_v),
        .o_ball_active (ball_active),
        .o_score_l     (score_l),
        .o_score_r     (score_r),
        .o_hit         (hit),
        .o_miss        (miss),
        .o_game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        int act;
        int sl;
        int sr;
        int hit;
        int miss;
        int over;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: game state in plain integers, mode 0 idle, 1 play, 2 scored, 3 over.
    int m_h, m_v, m_right, m_down, m_sl, m_sr, m_act, m_mode, m_hold, m_hit, m_miss, m_over;
    bit skill_l, skill_r;
    int games = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h = 316; m_v = 236; m_right = 1; m_down = 1;
        m_sl = 0; m_sr = 0; m_act = 0; m_mode = 0; m_hold = 0;
        m_hit = 0; m_miss = 0; m_over = 0;
    endtask

    function automatic int top_of(input int p);
        return (p * 2 > 400) ? 400 : p * 2;
    endfunction

    function automatic bit overlaps(input int v, input int top);
        return (v + 8 > top) && (v < top + 80);
    endfunction

    task automatic model_step(input bit tk, input bit sv, input int lp, input int rp);
        int nh, nv;
        bit hit_now, point_l, point_r;
        m_hit = 0;
        m_miss = 0;
        case (m_mode)
            0: if (sv) begin m_mode = 1; m_act = 1; end
            1: if (tk) begin
                hit_now = 0; point_l = 0; point_r = 0;
                if (m_right) begin
                    nh = m_h + 4;
                    if (m_h + 8 <= 616 && nh + 8 >= 616 && overlaps(m_v, top_of(rp))) begin
                        hit_now = 1; nh = 608;
                    end else if (nh >= 632) point_l = 1;
                end else begin
                    nh = m_h - 4;
                    if (m_h >= 24 && nh <= 24 && overlaps(m_v, top_of(lp))) begin
                        hit_now = 1; nh = 24;
                    end else if (m_h < 4) point_r = 1;
                end
                if (point_l || point_r) begin
                    m_miss = 1; m_act = 0;
                    if (point_l) begin m_sl++; m_right = 1; end
                    else begin m_sr++; m_right = 0; end
                    if (m_sl == 9 || m_sr == 9) begin m_mode = 3; m_over = 1; end
                    else begin m_mode = 2; m_hold = 0; end
                end else begin
                    nv = m_down ? m_v + 4 : m_v - 4;
                    if (m_down && nv >= 472) begin m_v = 472; m_down = 0; end
                    else if (!m_down && m_v < 4) begin m_v = 0; m_down = 1; end
                    else m_v = nv;
                    if (hit_now) begin m_hit = 1; m_right = !m_right; end
                    m_h = nh;
                end
            end
            2: if (tk) begin
                m_hold++;
                if (m_hold == 60) begin
                    m_hold = 0; m_h = 316; m_v = 236; m_act = 1; m_mode = 1;
                end
            end
            3: if (sv) begin
                m_sl = 0; m_sr = 0; m_h = 316; m_v = 236; m_right = 1;
                m_act = 1; m_over = 0; m_mode = 1; games++;
            end
            default: ;
        endcase
    endtask

    // A skilled paddle covers the ball row (including edge offsets); an unskilled one stays clear.
    function automatic logic [7:0] pick_paddle(input bit skilled, input int v);
        int top;
        if (skilled) begin
            if (v > 396) return 8'($urandom_range(200, 255));
            top = v - ($urandom_range(0, 84) - 6);
            if (top < 0) top = 0;
            return 8'(top / 2);
        end
        if (v >= 200) return 8'd0;
        return 8'($urandom_range(201, 255));
    endfunction

    task automatic drive_cycle(input bit tk, input bit sv);
        exp_t e;
        pl = pick_paddle(skill_l, m_v);
        pr = pick_paddle(skill_r, m_v);
        tick = tk;
        serve = sv;
        model_step(tk, sv, int'(pl), int'(pr));
        if (m_hit || m_miss) begin
            skill_l = ($urandom_range(0, 9) < 5);
            skill_r = ($urandom_range(0, 9) < 5);
        end
        e.h = m_h; e.v = m_v; e.act = m_act; e.sl = m_sl; e.sr = m_sr;
        e.hit = m_hit; e.miss = m_miss; e.over = m_over;
        q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ball_h"}, int'(ball_h), 316);
        chk({tag, "_ball_v"}, int'(ball_v), 236);
        chk({tag, "_active"}, int'(ball_active), 0);
        chk({tag, "_score_l"}, int'(score_l), 0);
        chk({tag, "_score_r"}, int'(score_r), 0);
        chk({tag, "_hit"}, int'(hit), 0);
        chk({tag, "_miss"}, int'(miss), 0);
        chk({tag, "_game_over"}, int'(game_over), 0);
    endtask

    // Monitor: every registered cycle produces one expected snapshot.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ball_h", int'(ball_h), e.h);
                chk("ball_v", int'(ball_v), e.v);
                chk("ball_active", int'(ball_active), e.act);
                chk("score_l", int'(score_l), e.sl);
                chk("score_r", int'(score_r), e.sr);
                chk("hit", int'(hit), e.hit);
                chk("miss", int'(miss), e.miss);
                chk("game_over", int'(game_over), e.over);
                if (e.hit != 0)
                    $display("%0t hit    h=%0d v=%0d", $time, e.h, e.v);
                if (e.miss != 0)
                    $display("%0t point  score %0d:%0d over=%0d", $time, e.sl, e.sr, e.over);
            end
        end
    end

    initial begin
        int  gap = 0;
        bit  did_rst_play = 0;
        bit  did_rst_hold = 0;
        bit  tk;
        bit  sv;
        rst_n = 1'b0; tick = 1'b0; serve = 1'b0; pl = 8'd0; pr = 8'd0;
        skill_l = 1; skill_r = 1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        // Serve coinciding with a frame tick must not move the ball.
        drive_cycle(1'b1, 1'b1);
        for (int cyc = 0; cyc < 60000 && games < 2; cyc++) begin
            @(negedge clk);
            if ((!did_rst_play && cyc >= 400 && m_mode == 1) ||
                (did_rst_play && !did_rst_hold && m_mode == 2 && m_hold == 30)) begin
                if (!did_rst_play) did_rst_play = 1; else did_rst_hold = 1;
                tick = 1'b0; serve = 1'b0;
                #2 rst_n = 1'b0;
                #1 check_reset_outputs(did_rst_hold ? "rst_hold" : "rst_play");
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
                $display("%0t reset applied, serving again", $time);
                drive_cycle(1'($urandom_range(0, 1)), 1'b1);
            end else begin
                tk = (gap == 0);
                if (tk) gap = $urandom_range(0, 2); else gap--;
                sv = ($urandom_range(0, 99) == 0);
                drive_cycle(tk, sv);
            end
        end
        @(negedge clk);
        tick = 1'b0; serve = 1'b0;
        repeat (3) @(negedge clk);
        chk("games_completed", (games >= 2) ? 1 : 0, 1);
        chk("resets_exercised", (did_rst_play && did_rst_hold) ? 1 : 0, 1);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
